// File: rtl/cnn_load_sequencer_if.sv
// Signal bundle between the load sequencer and its neighbours: decompressor,
// CNN data source, data memory, CNN core and CPU.
interface cnn_load_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              start;
  logic              stop;
  logic              send;
  logic              dec_done;
  logic              dec_busy;
  logic [4:0]        row_count;
  logic              data_valid;
  logic              data_last;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cnn_start;
  logic              cnn_done;
  logic              load_process;
  logic              cnn_image;
  logic              interrupt;
  logic              int_ack;

  modport master (
    input  start, stop, dec_done, dec_busy, data_valid, data_last, data_in,
           cnn_done, int_ack,
    output send, row_count, data_ready, mem_we, mem_addr, mem_wdata,
           cnn_start, load_process, cnn_image, interrupt
  );

  modport slave (
    output start, stop, dec_done, dec_busy, data_valid, data_last, data_in,
           cnn_done, int_ack,
    input  send, row_count, data_ready, mem_we, mem_addr, mem_wdata,
           cnn_start, load_process, cnn_image, interrupt
  );
endinterface

// File: rtl/cnn_load_sequencer.sv
// Frame controller for the CNN chip: loads image rows through the decompressor,
// streams data words into memory, launches the CNN and interrupts the CPU.
//  state    | meaning
//  IDLE     | waiting for start
//  IMG_REQ  | ready to request next compressed row (blocked by stop/dec_busy)
//  IMG_WAIT | row requested, waiting for dec_done
//  DATA     | accepting CNN data words into memory
//  RUN      | CNN computing, waiting for cnn_done
//  IRQ      | interrupt raised, waiting for int_ack
module cnn_load_sequencer #(
  parameter int NUM_ROWS  = 29,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input logic                   clk,
  input logic                   rst,
  cnn_load_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    IMG_REQ,
    IMG_WAIT,
    DATA,
    RUN,
    IRQ
  } state_t;

  localparam logic [4:0]      ROWS_END = 5'(NUM_ROWS);
  localparam logic [ADDR_W:0] WORD_END = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0] WORD_INC = (ADDR_W+1)'(1);

  state_t            state;
  // One bit wider than the address so the count after the final word cannot wrap.
  logic [ADDR_W:0]   word_count;
  logic              accept;
  logic [DATA_W-1:0] wdata_next;

  assign bus.data_ready = (state == DATA) && !bus.stop;
  assign accept         = bus.data_valid && bus.data_ready;
  assign wdata_next     = bus.data_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      word_count       <= '0;
      bus.send         <= 1'b0;
      bus.row_count    <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.cnn_start    <= 1'b0;
      bus.load_process <= 1'b0;
      bus.cnn_image    <= 1'b0;
      bus.interrupt    <= 1'b0;
    end else begin
      bus.send      <= 1'b0;
      bus.cnn_start <= 1'b0;
      bus.mem_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state            <= IMG_REQ;
            bus.load_process <= 1'b1;
            bus.row_count    <= '0;
            word_count       <= '0;
          end
        end
        IMG_REQ: begin
          if (!bus.stop && !bus.dec_busy) begin
            bus.send <= 1'b1;
            state    <= IMG_WAIT;
          end
        end
        IMG_WAIT: begin
          if (bus.dec_done) begin
            if (bus.row_count != ROWS_END) begin
              bus.row_count <= bus.row_count + 5'd1;
            end
            if (bus.row_count + 5'd1 >= ROWS_END) begin
              state         <= DATA;
              bus.cnn_image <= 1'b1;
            end else begin
              state <= IMG_REQ;
            end
          end
        end
        DATA: begin
          if (accept) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= word_count[ADDR_W-1:0];
            bus.mem_wdata <= wdata_next;
            word_count    <= word_count + WORD_INC;
            if (bus.data_last || word_count >= WORD_END) begin
              state            <= RUN;
              bus.load_process <= 1'b0;
              bus.cnn_image    <= 1'b0;
              bus.cnn_start    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.cnn_done) begin
            state         <= IRQ;
            bus.interrupt <= 1'b1;
          end
        end
        IRQ: begin
          if (bus.int_ack) begin
            state         <= IDLE;
            bus.interrupt <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
